// File: rtl/vfifo_sc_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// vfifo_sc_fifo_ctrl
//
// Single-clock FIFO controller in front of an external dual-port RAM
// (port A write-only, port B read-only, both clocked by clk). The RAM has a
// one-cycle registered read, which is hidden behind a two-entry output
// buffer (head + skid) so the show-ahead read side sustains one word per cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data      producer push request and data
//   wr_full             RAM holds DEPTH words; pushes are dropped
//   wr_ovf              same-cycle flag: wr_en while wr_full (push dropped)
//   rd_data, rd_valid   head-of-FIFO word and its valid flag
//   rd_ready            consumer accepts rd_data this cycle
//   level               words held: RAM + in flight + output buffer
//   ram_*_a             RAM write port (data, address = write pointer, enable)
//   ram_*_b             RAM read port (address = read pointer, tied-off write)
//   ram_q_b             RAM registered read data
// -----------------------------------------------------------------------------
module vfifo_sc_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_ovf,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    output logic [DATA_WIDTH-1:0] ram_d_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  in_flight_q, in_flight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  wr_full_q, wr_full_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH+1:0] level_q, level_d;

    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [2:0]            occ_s;
    logic [1:0]            buf_after_pop_s;

    // Handshakes, read-issue decision and RAM port drive.
    always_comb begin
        push_s  = wr_en & ~wr_full_q;
        pop_s   = rd_valid_q & rd_ready;
        // Words already committed downstream of the RAM after this cycle's pop.
        // A new read may issue only if that leaves a free buffer slot for it.
        occ_s   = {1'b0, buf_cnt_q} + {2'b00, in_flight_q} - {2'b00, pop_s};
        // ram_cnt only counts words written at earlier edges, so an issue can
        // never target the address being written in the same cycle.
        issue_s = (ram_cnt_q != {(ADDR_WIDTH+1){1'b0}}) & (occ_s < 3'd2);

        ram_d_a   = wr_data;
        ram_adr_a = wr_ptr_q;
        ram_we_a  = push_s;
        ram_adr_b = rd_ptr_q;
        ram_d_b   = {DATA_WIDTH{1'b0}};
        ram_we_b  = 1'b0;
    end

    // Pointer and RAM occupancy next state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        in_flight_d = issue_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (issue_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, issue_s})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    // Output buffer: pop shifts skid into head, then a landing word fills the
    // first free slot (head if it is empty after the pop, else skid).
    always_comb begin
        head_d          = head_q;
        skid_d          = skid_q;
        buf_cnt_d       = buf_cnt_q;
        buf_after_pop_s = buf_cnt_q;
        if (pop_s) begin
            buf_after_pop_s = buf_cnt_q - 2'd1;
            if (buf_cnt_q == 2'd2) begin
                head_d = skid_q;
            end else begin
                head_d = head_q;
            end
        end else begin
            buf_after_pop_s = buf_cnt_q;
        end
        if (in_flight_q) begin
            if (buf_after_pop_s == 2'd0) begin
                head_d = ram_q_b;
            end else begin
                skid_d = ram_q_b;
            end
            buf_cnt_d = buf_after_pop_s + 2'd1;
        end else begin
            buf_cnt_d = buf_after_pop_s;
        end
    end

    // Registered status outputs derived from next state.
    always_comb begin
        wr_full_d  = (ram_cnt_d == DEPTH_C);
        rd_valid_d = (buf_cnt_d != 2'd0);
        level_d    = {1'b0, ram_cnt_d}
                   + {{(ADDR_WIDTH+1){1'b0}}, in_flight_d}
                   + {{ADDR_WIDTH{1'b0}}, buf_cnt_d};
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
            ram_cnt_q   <= {(ADDR_WIDTH+1){1'b0}};
            in_flight_q <= 1'b0;
            buf_cnt_q   <= 2'd0;
            head_q      <= {DATA_WIDTH{1'b0}};
            skid_q      <= {DATA_WIDTH{1'b0}};
            wr_full_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            level_q     <= {(ADDR_WIDTH+2){1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            in_flight_q <= in_flight_d;
            buf_cnt_q   <= buf_cnt_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            wr_full_q   <= wr_full_d;
            rd_valid_q  <= rd_valid_d;
            level_q     <= level_d;
        end
    end

    // Output mapping; wr_ovf flags the dropped push in the cycle it is offered.
    always_comb begin
        wr_full  = wr_full_q;
        wr_ovf   = wr_en & wr_full_q;
        rd_data  = head_q;
        rd_valid = rd_valid_q;
        level    = level_q;
    end

endmodule

// File: tb/tb_vfifo_sc_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vfifo_sc_fifo_ctrl
//
// Self-checking bench. A behavioural RAM model is attached to the RAM ports.
// The reference model tracks each accepted word by index with its issue
// cycle: a word is read from RAM when it was written at an earlier edge, the
// previous word has issued, and the word two places ahead of it has left the
// FIFO; it becomes visible two cycles after issue. Outputs are compared with
// that model every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_vfifo_sc_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;
    localparam int MAXW  = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full, wr_ovf, rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready = 1'b0;
    logic [AW+1:0] level;
    logic [DW-1:0] ram_d_a, ram_d_b, ram_q_b;
    logic [AW-1:0] ram_adr_a, ram_adr_b;
    logic          ram_we_a, ram_we_b;

    vfifo_sc_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .wr_ovf(wr_ovf), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level),
        .ram_d_a(ram_d_a), .ram_adr_a(ram_adr_a), .ram_we_a(ram_we_a),
        .ram_adr_b(ram_adr_b), .ram_d_b(ram_d_b), .ram_we_b(ram_we_b),
        .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    // External RAM: write port A, registered read port B.
    logic [DW-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_q_b = '0;
    end
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= mem[ram_adr_b];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (word indices are global, never reused).
    logic [DW-1:0] m_data [0:MAXW-1];
    int            m_iss  [0:MAXW-1];
    int n_push = 0;
    int n_iss  = 0;
    int n_pop  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_full();
        return (n_push - n_iss) == DEPTH;
    endfunction

    function automatic bit m_valid();
        return (n_pop < n_iss) && (m_iss[n_pop] + 2 <= cyc);
    endfunction

    task automatic drive(input bit we, input logic [DW-1:0] d, input bit rr);
        wr_en = we; wr_data = d; rd_ready = rr;
        #1;
    endtask

    // One cycle: compare on the falling edge, advance the model, move past the edge.
    task automatic tick();
        bit push, pop, issue;
        @(negedge clk);
        if (rst_n) begin
            chk("wr_full", wr_full, m_full());
            chk("wr_ovf", wr_ovf, wr_en && m_full());
            chk("level", level, n_push - n_pop);
            chk("rd_valid", rd_valid, m_valid());
            if (m_valid()) chk("rd_data", rd_data, m_data[n_pop]);
            push  = wr_en && !m_full();
            pop   = m_valid() && rd_ready;
            issue = (n_iss < n_push) && (n_iss - n_pop - int'(pop) < 2);
            if (issue) begin m_iss[n_iss] = cyc; n_iss++; end
            if (pop) n_pop++;
            if (push) begin m_data[n_push] = wr_data; n_push++; end
        end else begin
            n_iss = n_push;
            n_pop = n_push;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int acc;
    logic [DW-1:0] d;

    initial begin
        // Reset state.
        drive(1'b1, 8'h33, 1'b1);
        tick(); tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_wr_ovf", wr_ovf, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;

        // 1: single push, 3-cycle latency, held with rd_ready low.
        drive(1'b1, 8'hA5, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("t1_c1_valid", rd_valid, 0);
        chk("t1_c1_level", level, 1);
        tick();
        chk("t1_c2_valid", rd_valid, 0);
        tick();
        chk("t1_c3_valid", rd_valid, 1);
        chk("t1_c3_data", rd_data, 8'hA5);
        chk("t1_c3_level", level, 1);
        tick(); tick();
        chk("t1_hold_data", rd_data, 8'hA5);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("t1_empty", rd_valid, 0);

        // 2: streaming with rd_ready high.
        for (int i = 0; i < DEPTH + 6; i++) begin
            drive(1'b1, DW'(i), 1'b1);
            if (i == 3) begin
                chk("t2_first_valid", rd_valid, 1);
                chk("t2_first_data", rd_data, 0);
            end
            if (i == 10) begin
                chk("t2_steady_data", rd_data, 7);
                chk("t2_steady_level", level, 3);
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin drive(1'b0, 8'h00, 1'b1); tick(); end
        chk("t2_drained_level", level, 0);

        // 3: fill until full, then one dropped push.
        acc = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            if (!wr_full) begin
                drive(1'b1, DW'(i * 3 + 1), 1'b0);
                tick();
                acc++;
            end
        end
        chk("t3_accepted", acc, DEPTH + 2);
        chk("t3_level", level, DEPTH + 2);
        chk("t3_full", wr_full, 1);
        drive(1'b1, 8'hEE, 1'b0);
        chk("t3_ovf", wr_ovf, 1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("t3_ovf_pulse", wr_ovf, 0);
        chk("t3_level_same", level, DEPTH + 2);
        tick();

        // 4: alternate push attempts with random rd_ready across pointer wrap.
        d = 8'h40;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            drive(k[0], d, 1'($urandom_range(0, 1)));
            tick();
            d = d + 8'd7;
        end
        for (int i = 0; i < DEPTH + 20; i++) begin drive(1'b0, 8'h00, 1'b1); tick(); end
        chk("t4_drained_level", level, 0);

        // 5: reset while a read is in flight.
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("t5_rst_level", level, 0);
        chk("t5_rst_valid", rd_valid, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("t5_no_stale_valid", rd_valid, 0);
            chk("t5_no_stale_level", level, 0);
            tick();
        end
        drive(1'b1, 8'h5C, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0); tick(); tick();
        chk("t5_after_valid", rd_valid, 1);
        chk("t5_after_data", rd_data, 8'h5C);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
